// File: rtl/lmac_fifo_pkg.sv
// Shared definitions for the LMAC clock-crossing FIFO read-side logic:
// FSM encoding, output buffer sizing and the position of the EOP flag.
package lmac_fifo_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } rd_state_t;

    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    // The EOP flag rides in the top bit of every FIFO word.
    function automatic int eop_idx(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered register buffer; entry 0 is always the head.
// Clear has priority over push and pop.
module fifo_rd_skid
    import lmac_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] entry_reg  [SKID_DEPTH];
    logic [WIDTH-1:0] entry_next [SKID_DEPTH];
    logic [OCC_W-1:0] occ_reg, occ_next, occ_kept;

    always_comb begin
        entry_next = entry_reg;
        occ_kept   = occ_reg;
        occ_next   = occ_reg;
        if (clear) begin
            occ_next = '0;
        end else begin
            if (pop && occ_reg != '0) begin
                for (int i = 0; i < SKID_DEPTH - 1; i++) begin
                    entry_next[i] = entry_reg[i + 1];
                end
                occ_kept = occ_reg - OCC_W'(1);
            end
            occ_next = occ_kept;
            // A same-cycle push lands behind whatever survives the pop.
            if (push && int'(occ_kept) < SKID_DEPTH) begin
                for (int i = 0; i < SKID_DEPTH; i++) begin
                    if (i == int'(occ_kept)) begin
                        entry_next[i] = push_data;
                    end
                end
                occ_next = occ_kept + OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            occ_reg <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else begin
            occ_reg <= occ_next;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
        end
    end

    assign head_data = entry_reg[0];
    assign occupancy = occ_reg;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain of the LMAC clock-crossing FIFO: turns rden/dataout into a
// valid/ready stream, counts delivered words/frames and runs the flush drain.
module fifo_rd_stream
    import lmac_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int PTR   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             fifo_rdempty,
    input  logic [PTR:0]     fifo_rdusedw,
    input  logic [WIDTH-1:0] fifo_dataout,
    output logic             fifo_rden,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_data,
    output logic             out_eop,
    input  logic             flush,
    output logic             flush_done,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int EOP_IDX = eop_idx(WIDTH);

    rd_state_t        state_reg, state_next;
    logic             inflight_reg;
    logic             flush_done_reg;
    logic [CNT_W-1:0] word_cnt_reg, frame_cnt_reg;
    logic [OCC_W-1:0] occ;
    logic [WIDTH-1:0] head;
    logic [OCC_W:0]   pending, room;
    logic             want, pop, push, clear, flush_exit;
    logic             usedw_unused;

    // Fill level is informational only; control relies on rdempty.
    assign usedw_unused = ^fifo_rdusedw;
    assign pending      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_reg};

    always_comb begin
        state_next = state_reg;
        want       = 1'b1;
        out_valid  = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        clear      = 1'b0;
        flush_exit = 1'b0;
        room       = '0;
        case (state_reg)
            ST_RUN: begin
                out_valid = (occ != '0);
                pop       = out_valid & out_ready;
                push      = inflight_reg;
                // A word leaving this clk frees its slot, which keeps one
                // word per clk flowing through only two entries.
                room      = (OCC_W+1)'(SKID_DEPTH - 1) + {{OCC_W{1'b0}}, pop};
                want      = (pending <= room);
                if (flush) begin
                    clear      = 1'b1;
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fifo_rdempty && !inflight_reg) begin
                    flush_exit = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign fifo_rden = reset_ & want & ~fifo_rdempty;

    fifo_rd_skid #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset_    (reset_),
        .push      (push),
        .push_data (fifo_dataout),
        .pop       (pop),
        .clear     (clear),
        .head_data (head),
        .occupancy (occ)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_reg      <= ST_RUN;
            inflight_reg   <= 1'b0;
            flush_done_reg <= 1'b0;
            word_cnt_reg   <= '0;
            frame_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            inflight_reg   <= fifo_rden;
            flush_done_reg <= flush_exit;
            if (pop) begin
                word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                if (out_eop) begin
                    frame_cnt_reg <= frame_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign out_data   = head[WIDTH-2:0];
    assign out_eop    = head[EOP_IDX];
    assign flush_done = flush_done_reg;
    assign word_cnt   = word_cnt_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO feeds the block and every
// delivered word is matched against the order in which words left the FIFO.
module tb_fifo_rd_stream;

    localparam int WIDTH = 8;
    localparam int PTR   = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_;
    logic             fifo_rdempty;
    logic [PTR:0]     fifo_rdusedw;
    logic [WIDTH-1:0] fifo_dataout;
    logic             fifo_rden;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-2:0] out_data;
    logic             out_eop;
    logic             flush;
    logic             flush_done;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .WIDTH(WIDTH),
        .PTR  (PTR),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .reset_       (reset_),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdusedw (fifo_rdusedw),
        .fifo_dataout (fifo_dataout),
        .fifo_rden    (fifo_rden),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_eop      (out_eop),
        .flush        (flush),
        .flush_done   (flush_done),
        .word_cnt     (word_cnt),
        .frame_cnt    (frame_cnt)
    );

    a_no_rden_when_empty: assert property (@(posedge clk) disable iff (!reset_)
        fifo_rden |-> !fifo_rdempty)
        else $error("FAIL rden_when_empty: fifo_rden=1 while fifo_rdempty=1");

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] fifo_q[$];   // words still held by the FIFO
    logic [WIDTH-1:0] exp_q[$];    // words read out, awaiting delivery
    int  m_words, m_frames;        // reference counters
    int  cyc, n_rden, n_done, n_valid, n_deliv, first_valid, last_valid;
    int  ready_mode, push_prob;
    bit  discard;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic sync_fifo();
        fifo_rdempty = (fifo_q.size() == 0);
        fifo_rdusedw = (PTR+1)'(fifo_q.size());
    endtask

    task automatic load_random(input int n, input bit rand_eop);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = {(rand_eop ? 1'($urandom) : 1'(i == n - 1)), (WIDTH-1)'($urandom)};
            fifo_q.push_back(w);
        end
        sync_fifo();
    endtask

    // One clock: sample and score at the falling edge, then update the FIFO
    // model and drive new inputs 1 time unit after the rising edge.
    task automatic cycle();
        logic [WIDTH-1:0] w;
        logic             rden_s;
        @(negedge clk);
        cyc++;
        check_val("word_cnt", 32'(word_cnt), 32'(m_words % (1 << CNT_W)));
        check_val("frame_cnt", 32'(frame_cnt), 32'(m_frames % (1 << CNT_W)));
        if (fifo_rden) begin
            n_rden++;
            check_val("rden_while_empty", 32'(fifo_rdempty), 0);
        end
        if (flush_done) n_done++;
        if (out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
            n_valid++;
        end
        if (out_valid && out_ready) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
                check_val("spurious_word", 32'({out_eop, out_data}), 32'hFFFF_FFFF);
                m_words++;
            end else begin
                w = exp_q.pop_front();
                check_val("stream_word", 32'({out_eop, out_data}), 32'(w));
                m_words++;
                if (w[WIDTH-1]) m_frames++;
            end
        end
        rden_s = fifo_rden;
        @(posedge clk);
        #1;
        if (rden_s && fifo_q.size() > 0) begin
            fifo_dataout = fifo_q.pop_front();
            if (!discard) exp_q.push_back(fifo_dataout);
        end
        if (push_prob > 0 && fifo_q.size() < 16 && $urandom_range(99) < push_prob)
            load_random(1, 1'b1);
        if (ready_mode == 1) out_ready = ~out_ready;
        else if (ready_mode == 2) out_ready = 1'($urandom_range(1));
        sync_fifo();
    endtask

    initial begin
        int base, d0, rem, snap_w, snap_f;
        reset_       = 1'b1;
        out_ready    = 1'b1;
        flush        = 1'b0;
        fifo_dataout = '0;
        ready_mode   = 0;
        push_prob    = 0;
        discard      = 1'b0;
        first_valid  = -1;
        sync_fifo();
        #2 reset_ = 1'b0;
        #1;
        check_val("reset_rden", 32'(fifo_rden), 0);
        check_val("reset_valid", 32'(out_valid), 0);
        check_val("reset_data", 32'({out_eop, out_data}), 0);
        check_val("reset_flush_done", 32'(flush_done), 0);
        check_val("reset_counts", 32'({word_cnt, frame_cnt}), 0);
        repeat (2) @(posedge clk);
        #1 reset_ = 1'b1;

        // Idle with an empty FIFO: nothing may be read or offered.
        repeat (20) cycle();
        check_val("idle_rden_pulses", n_rden, 0);
        check_val("idle_valid_cycles", n_valid, 0);

        // Five known words, last carries EOP: latency 2, then back-to-back.
        foreach (fifo_q[i]) fifo_q.delete(i);
        fifo_q.push_back(8'h01); fifo_q.push_back(8'h02); fifo_q.push_back(8'h03);
        fifo_q.push_back(8'h04); fifo_q.push_back(8'h85);
        sync_fifo();
        base = cyc + 1;
        first_valid = -1;
        n_valid = 0;
        repeat (12) cycle();
        check_val("first_valid_latency", first_valid - base, 2);
        check_val("last_valid_cycle", last_valid - base, 6);
        check_val("valid_cycle_count", n_valid, 5);
        check_val("t2_word_cnt", 32'(word_cnt), 5);
        check_val("t2_frame_cnt", 32'(frame_cnt), 1);

        // Backpressure: at most two reads, head held, then drain in order.
        out_ready = 1'b0;
        n_rden = 0;
        load_random(8, 1'b0);
        repeat (10) cycle();
        check_val("stall_rden_pulses", n_rden, 2);
        check_val("stall_valid", 32'(out_valid), 1);
        check_val("stall_head", 32'({out_eop, out_data}), 32'(exp_q[0]));
        out_ready = 1'b1;
        d0 = n_deliv;
        for (int i = 0; i < 40 && (n_deliv - d0) < 8; i++) cycle();
        check_val("stall_delivered", n_deliv - d0, 8);
        check_val("stall_leftover", exp_q.size() + fifo_q.size(), 0);

        // Toggling ready over 16 words.
        ready_mode = 1;
        load_random(16, 1'b1);
        d0 = n_deliv;
        for (int i = 0; i < 100 && (n_deliv - d0) < 16; i++) cycle();
        check_val("toggle_delivered", n_deliv - d0, 16);
        ready_mode = 0;
        out_ready  = 1'b0;

        // Flush with two words buffered and six left in the FIFO.
        load_random(8, 1'b0);
        repeat (6) cycle();
        check_val("pre_flush_fifo_level", fifo_q.size(), 6);
        snap_w = m_words;
        snap_f = m_frames;
        n_rden = 0;
        n_done = 0;
        discard = 1'b1;
        exp_q.delete();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_val("flush_valid_drop", 32'(out_valid), 0);
        for (int i = 0; i < 20 && n_done == 0; i++) cycle();
        repeat (3) cycle();
        discard = 1'b0;
        check_val("flush_done_pulses", n_done, 1);
        check_val("flush_rden_pulses", n_rden, 6);
        check_val("flush_word_cnt", 32'(word_cnt), 32'(snap_w));
        check_val("flush_frame_cnt", 32'(frame_cnt), 32'(snap_f));
        check_val("flush_rdempty", 32'(fifo_rdempty), 1);

        // Asynchronous reset mid-stream, then resume with the remaining words.
        out_ready = 1'b1;
        load_random(10, 1'b1);
        repeat (4) cycle();
        reset_ = 1'b0;
        #1;
        check_val("arst_rden", 32'(fifo_rden), 0);
        check_val("arst_valid", 32'(out_valid), 0);
        check_val("arst_data", 32'({out_eop, out_data}), 0);
        check_val("arst_counts", 32'({word_cnt, frame_cnt}), 0);
        exp_q.delete();
        m_words  = 0;
        m_frames = 0;
        rem = fifo_q.size();
        repeat (2) cycle();
        reset_ = 1'b1;
        d0 = n_deliv;
        for (int i = 0; i < 40 && (n_deliv - d0) < rem; i++) cycle();
        check_val("arst_resume_delivered", n_deliv - d0, rem);

        // Random traffic and random ready, then drain.
        ready_mode = 2;
        push_prob  = 40;
        repeat (400) cycle();
        push_prob  = 0;
        ready_mode = 0;
        out_ready  = 1'b1;
        for (int i = 0; i < 80 && (fifo_q.size() + exp_q.size()) > 0; i++) cycle();
        repeat (4) cycle();
        check_val("random_drain_left", exp_q.size() + fifo_q.size(), 0);
        check_val("random_valid_idle", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
